// File: rtl/phys_reg_file_mp.sv
// ============================================================================
// phys_reg_file_mp : multi-ported physical register file with ready scoreboard
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phys_reg_file_mp #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int DATA_W        = 32,
  parameter int NUM_RD        = 4,
  parameter int NUM_WB        = 2,
  parameter int NUM_ALLOC     = 1,
  localparam int LW           = $clog2(NUM_PHYS_REGS)
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     STALL,
  input  logic [NUM_RD-1:0]        RD_VALID_IN,
  input  logic [NUM_RD*LW-1:0]     RD_ADDR,
  output logic [NUM_RD-1:0]        RD_VALID_OUT,
  output logic [NUM_RD*DATA_W-1:0] RD_DATA,
  output logic [NUM_RD-1:0]        RD_READY,
  input  logic [NUM_WB-1:0]        WB_VALID,
  input  logic [NUM_WB*LW-1:0]     WB_ADDR,
  input  logic [NUM_WB*DATA_W-1:0] WB_DATA,
  input  logic [NUM_ALLOC-1:0]     ALLOC_VALID,
  input  logic [NUM_ALLOC*LW-1:0]  ALLOC_ADDR,
  output logic                     WB_CONFLICT
);

  logic [DATA_W-1:0]        r_mem [NUM_PHYS_REGS];
  logic [NUM_PHYS_REGS-1:0] r_rdy;

  logic [NUM_PHYS_REGS-1:0] w_wr_hit;
  logic [NUM_PHYS_REGS-1:0] w_alloc_hit;
  logic [DATA_W-1:0]        w_wr_data [NUM_PHYS_REGS];
  logic                     w_conflict;

  logic [LW-1:0]            r_rd_idx  [NUM_RD];
  logic [LW-1:0]            w_rd_idx  [NUM_RD];
  logic [DATA_W-1:0]        w_rd_data [NUM_RD];
  logic [NUM_RD-1:0]        w_rd_rdy;
  logic [NUM_RD-1:0]        w_snp_hit;
  logic [DATA_W-1:0]        w_snp_data [NUM_RD];

  // Per-register write/allocate decode; register 0 never matches, so it stays 0/ready.
  always_comb begin
    w_wr_hit    = '0;
    w_alloc_hit = '0;
    w_conflict  = 1'b0;
    for (int j = 0; j < NUM_PHYS_REGS; j++) begin
      w_wr_data[j] = '0;
    end
    for (int j = 1; j < NUM_PHYS_REGS; j++) begin
      for (int k = 0; k < NUM_WB; k++) begin
        if (WB_VALID[k] && (WB_ADDR[k*LW +: LW] == LW'(j))) begin
          w_wr_hit[j]  = 1'b1;
          w_wr_data[j] = WB_DATA[k*DATA_W +: DATA_W];
        end
      end
      for (int a = 0; a < NUM_ALLOC; a++) begin
        if (ALLOC_VALID[a] && (ALLOC_ADDR[a*LW +: LW] == LW'(j))) begin
          w_alloc_hit[j] = 1'b1;
        end
      end
    end
    for (int k0 = 0; k0 < NUM_WB; k0++) begin
      for (int k1 = k0 + 1; k1 < NUM_WB; k1++) begin
        if (WB_VALID[k0] && WB_VALID[k1] &&
            (WB_ADDR[k0*LW +: LW] == WB_ADDR[k1*LW +: LW]) &&
            (WB_ADDR[k0*LW +: LW] != '0)) begin
          w_conflict = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int j = 0; j < NUM_PHYS_REGS; j++) begin
        r_mem[j] <= '0;
      end
      r_rdy <= '1;
    end else begin
      for (int j = 1; j < NUM_PHYS_REGS; j++) begin
        if (w_wr_hit[j]) begin
          r_mem[j] <= w_wr_data[j];
        end
        // Allocate beats a same-cycle writeback on the ready bit.
        if (w_alloc_hit[j]) begin
          r_rdy[j] <= 1'b0;
        end else if (w_wr_hit[j]) begin
          r_rdy[j] <= 1'b1;
        end
      end
    end
  end

  // Read lookup sees this edge's writes and allocates (write-through bypass).
  always_comb begin
    w_rd_rdy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_rd_idx[i]  = RD_ADDR[i*LW +: LW];
      w_rd_data[i] = w_wr_hit[w_rd_idx[i]] ? w_wr_data[w_rd_idx[i]] : r_mem[w_rd_idx[i]];
      w_rd_rdy[i]  = w_alloc_hit[w_rd_idx[i]] ? 1'b0
                   : (w_wr_hit[w_rd_idx[i]] | r_rdy[w_rd_idx[i]]);
    end
  end

  // Writeback snoop for slots held under stall.
  always_comb begin
    w_snp_hit = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_snp_data[i] = '0;
      for (int k = 0; k < NUM_WB; k++) begin
        if (WB_VALID[k] && (WB_ADDR[k*LW +: LW] == r_rd_idx[i]) && (r_rd_idx[i] != '0)) begin
          w_snp_hit[i]  = 1'b1;
          w_snp_data[i] = WB_DATA[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      RD_VALID_OUT <= '0;
      RD_DATA      <= '0;
      RD_READY     <= '0;
      WB_CONFLICT  <= 1'b0;
      for (int i = 0; i < NUM_RD; i++) begin
        r_rd_idx[i] <= '0;
      end
    end else begin
      WB_CONFLICT <= w_conflict;
      for (int i = 0; i < NUM_RD; i++) begin
        if (!STALL) begin
          RD_VALID_OUT[i]              <= RD_VALID_IN[i];
          r_rd_idx[i]                  <= w_rd_idx[i];
          RD_DATA[i*DATA_W +: DATA_W]  <= w_rd_data[i];
          RD_READY[i]                  <= w_rd_rdy[i];
        end else if (RD_VALID_OUT[i] && !RD_READY[i] && w_snp_hit[i]) begin
          RD_DATA[i*DATA_W +: DATA_W]  <= w_snp_data[i];
          RD_READY[i]                  <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_phys_reg_file_mp.sv
// ============================================================================
// tb_phys_reg_file_mp : directed self-checking bench for phys_reg_file_mp
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phys_reg_file_mp;

  localparam int NPR = 64;
  localparam int DW  = 32;
  localparam int NR  = 4;
  localparam int NW  = 2;
  localparam int NA  = 1;
  localparam int LW  = 6;

  logic              CLK = 1'b0;
  logic              RESET_N;
  logic              STALL;
  logic [NR-1:0]     RD_VALID_IN;
  logic [NR*LW-1:0]  RD_ADDR;
  logic [NR-1:0]     RD_VALID_OUT;
  logic [NR*DW-1:0]  RD_DATA;
  logic [NR-1:0]     RD_READY;
  logic [NW-1:0]     WB_VALID;
  logic [NW*LW-1:0]  WB_ADDR;
  logic [NW*DW-1:0]  WB_DATA;
  logic [NA-1:0]     ALLOC_VALID;
  logic [NA*LW-1:0]  ALLOC_ADDR;
  logic              WB_CONFLICT;

  int n_chk  = 0;
  int n_pass = 0;

  phys_reg_file_mp #(
    .NUM_PHYS_REGS(NPR), .DATA_W(DW), .NUM_RD(NR), .NUM_WB(NW), .NUM_ALLOC(NA)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .STALL(STALL),
    .RD_VALID_IN(RD_VALID_IN), .RD_ADDR(RD_ADDR),
    .RD_VALID_OUT(RD_VALID_OUT), .RD_DATA(RD_DATA), .RD_READY(RD_READY),
    .WB_VALID(WB_VALID), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
    .ALLOC_VALID(ALLOC_VALID), .ALLOC_ADDR(ALLOC_ADDR),
    .WB_CONFLICT(WB_CONFLICT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    RD_VALID_IN = '0; RD_ADDR = '0;
    WB_VALID = '0; WB_ADDR = '0; WB_DATA = '0;
    ALLOC_VALID = '0; ALLOC_ADDR = '0;
  endtask

  task automatic rd(input int p, input logic [LW-1:0] a);
    RD_VALID_IN[p] = 1'b1;
    RD_ADDR[p*LW +: LW] = a;
  endtask

  task automatic wb(input int p, input logic [LW-1:0] a, input logic [DW-1:0] d);
    WB_VALID[p] = 1'b1;
    WB_ADDR[p*LW +: LW] = a;
    WB_DATA[p*DW +: DW] = d;
  endtask

  task automatic alloc(input logic [LW-1:0] a);
    ALLOC_VALID[0] = 1'b1;
    ALLOC_ADDR[LW-1:0] = a;
  endtask

  function automatic logic [DW-1:0] dat(input int p);
    return RD_DATA[p*DW +: DW];
  endfunction

  initial begin
    RESET_N = 1'b0;
    STALL   = 1'b0;
    clr();
    tick(); tick();
    check("rst_valid",    64'(RD_VALID_OUT), 64'h0);
    check("rst_data",     64'(RD_DATA),      64'h0);
    check("rst_ready",    64'(RD_READY),     64'h0);
    check("rst_conflict", 64'(WB_CONFLICT),  64'h0);
    RESET_N = 1'b1;
    tick();

    // Fresh register reads zero and ready.
    rd(0, 6'd5); tick();
    check("p5_valid", 64'(RD_VALID_OUT), 64'h1);
    check("p5_data",  64'(dat(0)),       64'h0);
    check("p5_ready", 64'(RD_READY[0]),  64'h1);

    // Allocate P7 while reading it: bypass reports not-ready.
    clr(); alloc(6'd7); rd(1, 6'd7); tick();
    check("alloc7_ready", 64'(RD_READY[1]), 64'h0);
    check("rdvalid_off",  64'(RD_VALID_OUT[0]), 64'h0);
    clr(); wb(0, 6'd7, 32'hDEADBEEF); rd(1, 6'd7); tick();
    check("byp7_data",  64'(dat(1)),       64'hDEADBEEF);
    check("byp7_ready", 64'(RD_READY[1]),  64'h1);

    // Same-register collision: highest port wins, one-cycle conflict pulse.
    clr(); wb(0, 6'd9, 32'h11); wb(1, 6'd9, 32'h22); tick();
    check("conf_pulse", 64'(WB_CONFLICT), 64'h1);
    clr(); rd(2, 6'd9); tick();
    check("conf_clear", 64'(WB_CONFLICT), 64'h0);
    check("p9_data",    64'(dat(2)),      64'h22);
    clr(); wb(0, 6'd0, 32'h1); wb(1, 6'd0, 32'h2); tick();
    check("conf_p0", 64'(WB_CONFLICT), 64'h0);

    // Two writebacks to distinct registers.
    clr(); wb(0, 6'd20, 32'hA0A0); wb(1, 6'd21, 32'hB1B1); tick();
    check("dist_conf", 64'(WB_CONFLICT), 64'h0);
    clr(); rd(0, 6'd20); rd(3, 6'd21); tick();
    check("p20_data", 64'(dat(0)), 64'hA0A0);
    check("p21_data", 64'(dat(3)), 64'hB1B1);

    // Stall snoop.
    clr(); alloc(6'd12); tick();
    clr(); rd(3, 6'd12); tick();
    check("p12_valid", 64'(RD_VALID_OUT[3]), 64'h1);
    check("p12_nrdy",  64'(RD_READY[3]),     64'h0);
    clr(); STALL = 1'b1; rd(3, 6'd5); wb(0, 6'd13, 32'h99); tick();
    check("stall_hold_rdy",  64'(RD_READY[3]),     64'h0);
    check("stall_hold_val",  64'(RD_VALID_OUT[3]), 64'h1);
    clr(); rd(3, 6'd5); wb(1, 6'd12, 32'h55); tick();
    check("snoop_data",  64'(dat(3)),       64'h55);
    check("snoop_ready", 64'(RD_READY[3]),  64'h1);
    clr(); tick();
    check("held_data", 64'(dat(3)), 64'h55);
    STALL = 1'b0; rd(3, 6'd12); tick();
    check("post_stall_data",  64'(dat(3)),      64'h55);
    check("post_stall_ready", 64'(RD_READY[3]), 64'h1);
    clr(); tick();
    check("valid_drop", 64'(RD_VALID_OUT[3]), 64'h0);

    // Allocate and write same cycle: data lands, ready stays 0.
    clr(); alloc(6'd3); wb(0, 6'd3, 32'h77); tick();
    clr(); rd(0, 6'd3); tick();
    check("p3_data",  64'(dat(0)),      64'h77);
    check("p3_ready", 64'(RD_READY[0]), 64'h0);

    // Register 0 ignores writes.
    clr(); wb(0, 6'd0, 32'hFF); tick();
    clr(); rd(0, 6'd0); tick();
    check("p0_data",  64'(dat(0)),      64'h0);
    check("p0_ready", 64'(RD_READY[0]), 64'h1);

    // Reset asserted mid-stall clears outputs immediately.
    clr(); rd(0, 6'd3); wb(0, 6'd9, 32'h1); wb(1, 6'd9, 32'h2); tick();
    check("pre_rst_conf", 64'(WB_CONFLICT), 64'h1);
    clr(); STALL = 1'b1; tick();
    RESET_N = 1'b0; #1;
    check("mid_rst_valid", 64'(RD_VALID_OUT), 64'h0);
    check("mid_rst_data",  64'(RD_DATA),      64'h0);
    check("mid_rst_ready", 64'(RD_READY),     64'h0);
    check("mid_rst_conf",  64'(WB_CONFLICT),  64'h0);
    tick();
    RESET_N = 1'b1; STALL = 1'b0;
    rd(1, 6'd9); rd(2, 6'd12); tick();
    check("rst_p9_data",   64'(dat(1)),          64'h0);
    check("rst_p12_ready", 64'(RD_READY[2]),     64'h1);
    check("rst_valid_out", 64'(RD_VALID_OUT),    64'h6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
